// File: rtl/dp_prbs_checker.sv
// Serial PRBS7 (x^7+x^6+1) checker that self-synchronises to the stream leaving a
// data_path chain, then counts bit errors while locked.
module dp_prbs_checker #(
    parameter int LOCK_BITS   = 16,
    parameter int LOSS_ERRORS = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic             clr,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [2:0] SEED_LAST = 3'd6;
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_BITS - 1);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_ERRORS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    state_t     state_nxt;
    logic [6:0] h;
    logic [2:0] seed_cnt;
    logic [7:0] match_cnt;
    logic [3:0] loss_cnt;

    logic pred;
    logic mis;
    logic match_hit;
    logic feed;

    logic             locked_nxt;
    logic             error_nxt;
    logic             count_bit;
    logic [CNT_W-1:0] err_count_nxt;
    logic [CNT_W-1:0] bit_count_nxt;

    assign pred      = h[6] ^ h[5];
    assign mis       = in ^ pred;
    // An all-zero history predicts zeros forever, so it must never build confidence.
    assign match_hit = !mis && (h != 7'd0);
    // Once locked the history free-runs on its own prediction, so input errors
    // cannot corrupt the reference.
    assign feed      = (state == LOCKED) ? pred : in;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else begin
            // NOTE: sequential state uses non-blocking (<=) so every register samples
            // pre-edge values; blocking here would create order-dependent races.
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned,
        // which would otherwise infer a latch.
        state_nxt = state;
        if (en) begin
            unique case (state)
                SEED: begin
                    if (seed_cnt == SEED_LAST) state_nxt = VERIFY;
                end
                VERIFY: begin
                    if (match_hit && (match_cnt == LOCK_LAST)) state_nxt = LOCKED;
                end
                LOCKED: begin
                    if (mis && (loss_cnt == LOSS_LAST)) state_nxt = SEED;
                end
                default: state_nxt = SEED;
            endcase
        end
    end

    // History and per-state counters; each counter is zero outside its own state,
    // so entering a state always starts it from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h         <= 7'd0;
            seed_cnt  <= 3'd0;
            match_cnt <= 8'd0;
            loss_cnt  <= 4'd0;
        end else if (en) begin
            h         <= {h[5:0], feed};
            seed_cnt  <= (state == SEED) ? seed_cnt + 3'd1 : 3'd0;
            match_cnt <= (state == VERIFY && match_hit) ? match_cnt + 8'd1 : 8'd0;
            loss_cnt  <= (state == LOCKED && mis) ? loss_cnt + 4'd1 : 4'd0;
        end
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        locked_nxt    = (state_nxt == LOCKED);
        count_bit     = en && (state == LOCKED);
        error_nxt     = count_bit && mis;
        err_count_nxt = err_count;
        bit_count_nxt = bit_count;
        if (clr) begin
            err_count_nxt = '0;
            bit_count_nxt = '0;
        end else begin
            if (error_nxt && (err_count != CNT_MAX)) err_count_nxt = err_count + 1'b1;
            if (count_bit && (bit_count != CNT_MAX)) bit_count_nxt = bit_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked    <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            locked    <= locked_nxt;
            error     <= error_nxt;
            err_count <= err_count_nxt;
            bit_count <= bit_count_nxt;
        end
    end

endmodule

// File: tb/tb_dp_prbs_checker.sv
// Directed bench for dp_prbs_checker: a default instance and a CNT_W=4 instance share
// stimulus; a reference model feeds a per-cycle scoreboard alongside directed checks.
module tb_dp_prbs_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in;
    logic        clr;
    logic        locked;
    logic        error;
    logic [15:0] err_count;
    logic [15:0] bit_count;
    logic        locked_s;
    logic        error_s;
    logic [3:0]  err_count_s;
    logic [3:0]  bit_count_s;

    always #5 clk = ~clk;

    dp_prbs_checker dut (
        .clk(clk), .rst(rst), .en(en), .in(in), .clr(clr),
        .locked(locked), .error(error), .err_count(err_count), .bit_count(bit_count)
    );

    dp_prbs_checker #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .en(en), .in(in), .clr(clr),
        .locked(locked_s), .error(error_s), .err_count(err_count_s), .bit_count(bit_count_s)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic locked;
        logic error;
        int   errs;
        int   bits;
    } exp_t;

    exp_t sb[$];

    // Reference model: true (unbounded) counts; saturation applied at compare time.
    int       m_state;  // 0 seed, 1 verify, 2 locked
    bit [6:0] m_h;
    int       m_seed, m_match, m_loss, m_errs, m_bits;
    bit       m_error;
    bit [6:0] g;

    task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task model_reset();
        m_state = 0; m_h = 7'd0; m_seed = 0; m_match = 0; m_loss = 0;
        m_errs = 0; m_bits = 0; m_error = 1'b0;
    endtask

    task model_step(input logic e, input logic b, input logic c);
        bit p;
        m_error = 1'b0;
        if (e) begin
            p = m_h[6] ^ m_h[5];
            if (m_state == 0) begin
                m_h = {m_h[5:0], b};
                m_seed++;
                if (m_seed == 7) begin m_state = 1; m_match = 0; end
            end else if (m_state == 1) begin
                if (b == p && m_h != 7'd0) m_match++; else m_match = 0;
                m_h = {m_h[5:0], b};
                if (m_match == 16) begin m_state = 2; m_loss = 0; end
            end else begin
                m_bits++;
                if (b != p) begin m_error = 1'b1; m_errs++; m_loss++; end
                else m_loss = 0;
                m_h = {m_h[5:0], p};
                if (m_loss == 4) begin m_state = 0; m_seed = 0; end
            end
        end
        if (c) begin m_errs = 0; m_bits = 0; end
    endtask

    task gen_bit(output logic b);
        b = g[6] ^ g[5];
        g = {g[5:0], b};
    endtask

    task step(input logic e, input logic b, input logic c);
        exp_t x;
        @(negedge clk);
        en = e; in = b; clr = c;
        model_step(e, b, c);
        x.locked = (m_state == 2);
        x.error  = m_error;
        x.errs   = m_errs;
        x.bits   = m_bits;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("sb_locked", 32'(locked), 32'(x.locked));
        check("sb_error", 32'(error), 32'(x.error));
        check("sb_err_count", 32'(err_count), sat(x.errs, 65535));
        check("sb_bit_count", 32'(bit_count), sat(x.bits, 65535));
        check("sb_locked_s", 32'(locked_s), 32'(x.locked));
        check("sb_err_count_s", 32'(err_count_s), sat(x.errs, 15));
        check("sb_bit_count_s", 32'(bit_count_s), sat(x.bits, 15));
    endtask

    task prbs(input int n, input logic inv);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen_bit(b);
            step(1'b1, b ^ inv, 1'b0);
        end
    endtask

    task do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        g = 7'h7F;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic b;
        rst = 1'b1; en = 1'b0; in = 1'b0; clr = 1'b0;
        model_reset();
        g = 7'h7F;
        repeat (2) @(negedge clk);
        check("rst_locked", 32'(locked), 0);
        check("rst_error", 32'(error), 0);
        check("rst_err_count", 32'(err_count), 0);
        check("rst_bit_count", 32'(bit_count), 0);
        rst = 1'b0;

        // Clean lock at the 23rd bit, then 1000 clean bits
        prbs(22, 1'b0);
        check("not_locked_22", 32'(locked), 0);
        prbs(1, 1'b0);
        check("locked_23", 32'(locked), 1);
        prbs(1000, 1'b0);
        check("clean_err_count", 32'(err_count), 0);
        check("clean_bit_count", 32'(bit_count), 1000);

        // Single error at bit 100 after the clean run
        prbs(99, 1'b0);
        prbs(1, 1'b1);
        check("single_err_pulse", 32'(error), 1);
        prbs(1, 1'b0);
        check("single_err_gone", 32'(error), 0);
        check("single_err_count", 32'(err_count), 1);
        check("single_err_locked", 32'(locked), 1);

        // Clear on a clean counted bit, then loss of lock
        gen_bit(b);
        step(1'b1, b, 1'b1);
        check("clr_err_count", 32'(err_count), 0);
        check("clr_bit_count", 32'(bit_count), 0);
        for (int i = 0; i < 4; i++) begin
            prbs(1, 1'b1);
            check("loss_pulse", 32'(error), 1);
            if (i < 3) check("loss_still_locked", 32'(locked), 1);
        end
        check("loss_unlocked", 32'(locked), 0);
        check("loss_err_count", 32'(err_count), 4);
        prbs(22, 1'b0);
        check("relock_not_22", 32'(locked), 0);
        prbs(1, 1'b0);
        check("relock_23", 32'(locked), 1);

        // All-zero input never locks
        do_reset();
        for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0);
        check("zeros_unlocked", 32'(locked), 0);

        // Gated PRBS: lock after 23 enabled bits, bits counted only when enabled
        do_reset();
        for (int i = 0; i < 23; i++) begin
            gen_bit(b);
            step(1'b1, b, 1'b0);
            if (i == 21) check("gated_not_22", 32'(locked), 0);
            step(1'b0, 1'($urandom), 1'b0);
            check("gated_idle_error", 32'(error), 0);
        end
        check("gated_locked", 32'(locked), 1);
        check("gated_bit_count0", 32'(bit_count), 0);
        for (int i = 0; i < 10; i++) begin
            gen_bit(b);
            step(1'b1, b, 1'b0);
            step(1'b0, 1'($urandom), 1'b0);
        end
        check("gated_bit_count10", 32'(bit_count), 10);

        // Saturation at CNT_W=4 with non-consecutive errors, then clr beats an error
        for (int i = 0; i < 20; i++) begin
            prbs(2, 1'b0);
            prbs(1, 1'b1);
        end
        check("sat_err_count_s", 32'(err_count_s), 15);
        check("sat_err_count", 32'(err_count), 20);
        check("sat_locked", 32'(locked_s), 1);
        gen_bit(b);
        step(1'b1, ~b, 1'b1);
        check("clr_wins_pulse", 32'(error), 1);
        check("clr_wins_s", 32'(err_count_s), 0);
        check("clr_wins", 32'(err_count), 0);

        // Asynchronous reset while locked with three errors counted
        for (int i = 0; i < 3; i++) begin
            prbs(2, 1'b0);
            prbs(1, 1'b1);
        end
        check("pre_rst_err_count", 32'(err_count), 3);
        check("pre_rst_locked", 32'(locked), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_locked", 32'(locked), 0);
        check("async_rst_error", 32'(error), 0);
        check("async_rst_err_count", 32'(err_count), 0);
        check("async_rst_bit_count", 32'(bit_count), 0);
        check("async_rst_err_count_s", 32'(err_count_s), 0);
        model_reset();
        g = 7'h7F;
        @(negedge clk);
        rst = 1'b0;
        prbs(23, 1'b0);
        check("post_rst_locked", 32'(locked), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
